// File: rtl/sobel_pkg.sv
// Shared types, kernel weights and width helper for the streaming Sobel gradient stage.
package sobel_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_e;

    typedef enum logic {
        DIR_GX = 1'b0,
        DIR_GY = 1'b1
    } kernel_dir_e;

    localparam int unsigned KW_EDGE   = 1;
    localparam int unsigned KW_CENTER = 2;

    // Signed gradient width: 4x pixel magnitude plus sign, with headroom.
    function automatic int grad_width(input int pixel_size);
        return pixel_size + 6;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// One-row delay line addressed by column: the stored pixel is read out before it is
// overwritten on each enabled cycle. Contents are not reset.
module line_buffer
    import sobel_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int DEPTH = 640
) (
    input  logic                     clk,
    input  logic                     en_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic [WIDTH-1:0]         data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    assign data_o = mem_q[addr_i];

    always_ff @(posedge clk) begin
        if (en_i) begin
            mem_q[addr_i] <= data_i;
        end
    end

endmodule

// File: rtl/sobel_convolve.sv
// Streaming 3x3 Sobel gradient (Gx or Gy chosen at start of frame), two-stage output pipeline.
// Optional frame_done output is enabled by defining SOBEL_FRAME_DONE_EN.
//
//   state | meaning
//   IDLE  | waiting for a valid pixel flagged with sof
//   FILL  | rows 0-1: priming line buffers, no outputs
//   RUN   | rows 2..H-1: every pixel with col>=2 completes a window
module sobel_convolve
    import sobel_pkg::*;
#(
    parameter int PIXEL_SIZE = 12,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [PIXEL_SIZE-1:0]        pixel_in,
    input  logic                         valid_in,
    input  logic                         sof,
    input  logic                         dir,
    output logic signed [PIXEL_SIZE+5:0] pixel_out,
    output logic                         valid_out
`ifdef SOBEL_FRAME_DONE_EN
    ,
    output logic                         frame_done
`endif
);

    localparam int OW = grad_width(PIXEL_SIZE);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic signed [OW-1:0] K_E = OW'(KW_EDGE);
    localparam logic signed [OW-1:0] K_C = OW'(KW_CENTER);

    state_e                 state_q, state_d;
    logic [CW-1:0]          col_q, col_d, pix_col;
    logic [RW-1:0]          row_q, row_d, pix_row;
    kernel_dir_e            dir_q, dir_d;
    logic                   accept, restart, last_px, emit, emit_q;
    logic [PIXEL_SIZE-1:0]  lb1_out, lb2_out;
    logic [PIXEL_SIZE-1:0]  win_q [3][3];
    logic [PIXEL_SIZE-1:0]  col_new [3];
    logic signed [OW-1:0]   pos_d, neg_d, pos_q, neg_q;

    function automatic logic signed [OW-1:0] zx(input logic [PIXEL_SIZE-1:0] p);
        return $signed({{(OW - PIXEL_SIZE){1'b0}}, p});
    endfunction

    // sof restarts the frame from any state, so the accepted pixel is (0,0).
    assign restart = valid_in && sof;
    assign accept  = valid_in && ((state_q != IDLE) || sof);
    assign pix_col = restart ? '0 : col_q;
    assign pix_row = restart ? '0 : row_q;
    assign last_px = (pix_row == ROW_LAST) && (pix_col == COL_LAST);
    assign emit    = accept && (pix_row >= RW'(2)) && (pix_col >= CW'(2));

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        dir_d   = dir_q;
        if (accept) begin
            if (restart) begin
                dir_d = kernel_dir_e'(dir);
            end
            if (pix_col == COL_LAST) begin
                col_d = '0;
                row_d = last_px ? '0 : pix_row + 1'b1;
            end else begin
                col_d = pix_col + 1'b1;
                row_d = pix_row;
            end
            if (last_px) begin
                state_d = IDLE;
            end else if ((pix_row == RW'(1)) && (pix_col == COL_LAST)) begin
                state_d = RUN;
            end else if (restart) begin
                state_d = FILL;
            end
        end
    end

    line_buffer #(.WIDTH(PIXEL_SIZE), .DEPTH(IMG_WIDTH)) u_lb1 (
        .clk    (clk),
        .en_i   (accept),
        .addr_i (pix_col),
        .data_i (pixel_in),
        .data_o (lb1_out)
    );

    line_buffer #(.WIDTH(PIXEL_SIZE), .DEPTH(IMG_WIDTH)) u_lb2 (
        .clk    (clk),
        .en_i   (accept),
        .addr_i (pix_col),
        .data_i (lb1_out),
        .data_o (lb2_out)
    );

    assign col_new[0] = lb2_out;
    assign col_new[1] = lb1_out;
    assign col_new[2] = pixel_in;

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win_q[r][0] <= win_q[r][1];
                win_q[r][1] <= win_q[r][2];
                win_q[r][2] <= col_new[r];
            end
        end
    end

    // Sums are taken from the window as it will be after this pixel shifts in.
    always_comb begin
        if (dir_q == DIR_GX) begin
            pos_d = K_E * zx(col_new[0]) + K_C * zx(col_new[1]) + K_E * zx(col_new[2]);
            neg_d = K_E * zx(win_q[0][1]) + K_C * zx(win_q[1][1]) + K_E * zx(win_q[2][1]);
        end else begin
            pos_d = K_E * zx(win_q[2][1]) + K_C * zx(win_q[2][2]) + K_E * zx(col_new[2]);
            neg_d = K_E * zx(win_q[0][1]) + K_C * zx(win_q[0][2]) + K_E * zx(col_new[0]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            col_q     <= '0;
            row_q     <= '0;
            dir_q     <= DIR_GX;
            emit_q    <= 1'b0;
            pos_q     <= '0;
            neg_q     <= '0;
            valid_out <= 1'b0;
            pixel_out <= '0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            dir_q     <= dir_d;
            emit_q    <= emit;
            if (emit) begin
                pos_q <= pos_d;
                neg_q <= neg_d;
            end
            valid_out <= emit_q;
            if (emit_q) begin
                pixel_out <= pos_q - neg_q;
            end
        end
    end

`ifdef SOBEL_FRAME_DONE_EN
    logic done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            done_q     <= emit && last_px;
            frame_done <= done_q;
        end
    end
`endif

endmodule
